// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, stop-bit constants and the TX frame state type.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_START,
        ST_DATA,
        ST_PARITY,
`ifdef UART_TX_BREAK_EN
        ST_STOP,
        ST_BREAK
`else
        ST_STOP
`endif
    } tx_state_e;

    // 2'b11 is treated like PAR_NONE: no parity bit on the line.
    function automatic logic has_parity(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_bit_counter.sv
// Loadable down-counter advanced by baud_tick; flags zero for the frame sequencer.
module uart_bit_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && (count != '0))
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit frame serializer: start, DATA_W bits LSB first, optional parity, 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the send_break input and the BREAK state.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BREAK_BITS = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              send,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_bit,
    input  logic [1:0]        parity_type,
    input  logic              stop_bits,
    output logic              data_tx,
    output logic              busy,
    output logic              active_flag,
    output logic              done_flag
`ifdef UART_TX_BREAK_EN
    ,
    input  logic              send_break
`endif
);

    localparam int CNT_W = ($clog2(BREAK_BITS) > $clog2(DATA_W)) ? $clog2(BREAK_BITS) : $clog2(DATA_W);

    tx_state_e         state, state_nx;
    logic [DATA_W-1:0] shreg;
    logic              par_q, stop_q, tx_q, tx_nx, done_q, done_nx;
    logic [1:0]        ptype_q;
    logic              latch, shift, cnt_load, cnt_zero, req;
    logic [CNT_W-1:0]  cnt_val;

`ifdef UART_TX_BREAK_EN
    logic brk_q;
    assign req = send | send_break;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            brk_q <= 1'b0;
        else if (latch)
            brk_q <= ~send;
    end
`else
    assign req = send;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            shreg   <= '0;
            par_q   <= 1'b0;
            ptype_q <= PAR_NONE;
            stop_q  <= STOP_ONE;
        end else begin
            state  <= state_nx;
            tx_q   <= tx_nx;
            done_q <= done_nx;
            if (latch) begin
                shreg   <= data_in;
                par_q   <= parity_bit;
                ptype_q <= parity_type;
                stop_q  <= stop_bits;
            end else if (shift) begin
                shreg <= shreg >> 1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        tx_nx    = tx_q;
        done_nx  = 1'b0;
        latch    = 1'b0;
        shift    = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            // done_q holds off acceptance for the cycle that busy is still high
            ST_IDLE: begin
                tx_nx = 1'b1;
                if (!done_q && req) begin
                    latch    = 1'b1;
                    state_nx = ST_ARMED;
                end
            end
            ST_ARMED: if (baud_tick) begin
                tx_nx    = 1'b0;
                state_nx = ST_START;
`ifdef UART_TX_BREAK_EN
                if (brk_q) begin
                    state_nx = ST_BREAK;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(BREAK_BITS - 1);
                end
`endif
            end
            ST_START: if (baud_tick) begin
                state_nx = ST_DATA;
                tx_nx    = shreg[0];
                shift    = 1'b1;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(DATA_W - 1);
            end
            ST_DATA: if (baud_tick) begin
                if (!cnt_zero) begin
                    tx_nx = shreg[0];
                    shift = 1'b1;
                end else if (has_parity(ptype_q)) begin
                    state_nx = ST_PARITY;
                    tx_nx    = par_q;
                end else begin
                    state_nx = ST_STOP;
                    tx_nx    = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = (stop_q == STOP_TWO) ? CNT_W'(1) : '0;
                end
            end
            ST_PARITY: if (baud_tick) begin
                state_nx = ST_STOP;
                tx_nx    = 1'b1;
                cnt_load = 1'b1;
                cnt_val  = (stop_q == STOP_TWO) ? CNT_W'(1) : '0;
            end
            ST_STOP: if (baud_tick && cnt_zero) begin
                state_nx = ST_IDLE;
                tx_nx    = 1'b1;
                done_nx  = 1'b1;
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: if (baud_tick && cnt_zero) begin
                state_nx = ST_IDLE;
                tx_nx    = 1'b1;
                done_nx  = 1'b1;
            end
`endif
            default: begin
                state_nx = ST_IDLE;
                tx_nx    = 1'b1;
            end
        endcase
    end

    uart_bit_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (baud_tick),
        .zero     (cnt_zero)
    );

    assign data_tx     = tx_q;
    assign done_flag   = done_q;
    assign busy        = (state != ST_IDLE) || done_q;
    assign active_flag = (state != ST_IDLE) && (state != ST_ARMED);

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Transmit-side frame serializer. It consumes the byte from the input register and the parity bit produced by the parity unit, and drives the serial line with start, data (LSB first), optional parity, and 1 or 2 stop bits. Bit timing comes from an external one-cycle baud_tick strobe. It sits between the parity unit and the TX pin.

Parameters:
- DATA_W, 8, data bits per frame; legal values 5..8.
- BREAK_BITS, 13, bit periods of low line for a break (only used with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- baud_tick  in  1  one-clk pulse per bit period
- send  in  1  request to transmit; accepted only when busy=0
- data_in  in  DATA_W  byte to send; sampled on acceptance
- parity_bit  in  1  from parity unit; sampled on acceptance
- parity_type  in  2  01=odd, 10=even, 00/11=no parity bit
- stop_bits  in  1  0=one stop bit, 1=two stop bits; sampled on acceptance
- data_tx  out  1  serial line, idle high
- busy  out  1  high from the acceptance cycle until the cycle after done_flag
- active_flag  out  1  high while a frame bit (start..stop) is on the line
- done_flag  out  1  one-clk pulse when the last stop bit completes

Behaviour:
- Reset (async, any state): state=IDLE; data_tx=1; busy=0; active_flag=0; done_flag=0; latches cleared. Reset mid-frame aborts the frame and the line returns high immediately.
- States: IDLE, ARMED, START, DATA, PARITY, STOP.
- IDLE: if send=1, latch data_in, parity_bit, parity_type, stop_bits; go to ARMED; busy=1 from the next cycle. send while busy=1 is ignored, with no queueing.
- ARMED: wait for baud_tick, then go to START. This guarantees every bit is a full period.
- All bit changes occur only in the cycle after a baud_tick; state and the line are registered. START drives 0.
- DATA: shift out bit index 0..DATA_W-1, LSB first, one per tick. The bit counter is log2 wide and wraps/clears on exit.
- PARITY: entered only if the latched parity_type is 01 or 10. Drives the latched parity_bit for one period. Otherwise DATA goes straight to STOP.
- STOP: drives 1 for 1 or 2 periods.
- On the tick ending the final stop period: done_flag=1 for one clk, state=IDLE, busy=0 in the following cycle. send is accepted again from that cycle.
- active_flag=1 in START/DATA/PARITY/STOP, 0 otherwise.
- Frame length in ticks (8-bit): 8N1=10, 8O1/8E1=11, 8N2=11, 8E2/8O2=12. Plus up to one tick of ARMED latency.
- Simultaneous send and baud_tick in IDLE: the request is accepted and the state goes to ARMED. That tick is not consumed; START begins on the next tick.
- Input changes after acceptance have no effect on the current frame.
- baud_tick asserted for more than one clk counts as multiple ticks; callers must supply single-cycle pulses.

Optional Feature:
- Macro UART_TX_BREAK_EN.
- Defined: adds input port send_break. In IDLE with send=0 and send_break=1, go to state BREAK. BREAK drives data_tx=0 for BREAK_BITS ticks (aligned via ARMED), with busy=1 and active_flag=1, then done_flag pulses and the state returns to IDLE. send has priority if both are asserted.
- Undefined: no send_break port and no BREAK state.

Decomposition:
- Shared package uart_pkg holds:
  - parity encodings PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10 (shared with the parity unit);
  - the state enum typedef;
  - STOP_ONE/STOP_TWO constants.
- One natural sub-module: uart_bit_counter, a loadable down-counter with an enable on baud_tick, used for the data bits, stop bits and break length.

Test Plan:
- 8E1: data 0xA5, parity_bit=0, send with periodic ticks -> line 0,1,0,1,0,0,1,0,1,0,1. The frame is 11 ticks; done_flag is a single pulse; busy clears one cycle later.
- 8N1 (parity_type=00) and 8N1 with parity_type=11: data 0x3C -> line 0,0,0,1,1,1,1,0,0,1, 10 ticks, no parity bit.
- 8O2: data 0x00, parity_bit=1, stop_bits=1 -> 0,0×8,1,1,1. The frame is 12 ticks. A second send pulsed mid-frame is ignored.
- Back-to-back: send asserted in the cycle after done_flag with data 0xFF.
  - The new frame starts on the next tick.
  - The line is never low outside a start bit.
- Reset asserted during the DATA bit 3 period:
  - data_tx=1, busy=0 and done_flag=0 immediately;
  - after release, the next send produces a full, correct frame.
- UART_TX_BREAK_EN, BREAK_BITS=13: pulse send_break -> data_tx low for exactly 13 ticks, then done_flag, then idle high.
